// File: rtl/meas_pkg.sv
// Shared definitions for the measurement sequencer: FSM state encoding,
// register map addresses and the CTRL/STATUS bit positions.
package meas_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_STOP,
    S_CAPTURE
  } state_t;

  // Register map
  localparam int unsigned A_CTRL     = 0;
  localparam int unsigned A_PERIOD_L = 1;
  localparam int unsigned A_PERIOD_H = 2;
  localparam int unsigned A_WIDTH_L  = 3;
  localparam int unsigned A_WIDTH_H  = 4;
  localparam int unsigned A_GATE_L   = 5;
  localparam int unsigned A_GATE_H   = 6;
  localparam int unsigned A_STATUS   = 7;
  localparam int unsigned A_RESULT_L = 8;
  localparam int unsigned A_RESULT_H = 9;

  // CTRL bits
  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_CONT    = 2;
  localparam int unsigned CTRL_CLR_ERR = 3;

  // STATUS bits
  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_ERR  = 2;

  // Byte lane of a 16-bit value for the 8-bit read port.
  function automatic logic [7:0] byte_sel(input logic [15:0] v, input logic hi);
    return hi ? v[15:8] : v[7:0];
  endfunction

endpackage

// File: rtl/meas_regfile.sv
// Register file for the measurement sequencer.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   wr_en, addr,      byte write interface from the I2C decoder
//   wr_data
//   rd_data           combinational read of the addressed register
//   busy, done_stky,  status inputs from the sequencer (STATUS / RESULT)
//   err, result
//   start_stb,        single-cycle command strobes, decoded straight from the
//   abort_stb,        CTRL write so the sequencer reacts on the following edge
//   clr_err_stb
//   cont              persistent continuous-mode bit
//   period_reg,       configuration registers
//   width_reg,
//   gate_reg
module meas_regfile
  import meas_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DEF_PERIOD = 10,
  parameter int unsigned DEF_WIDTH  = 2,
  parameter int unsigned DEF_GATE   = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        rd_data,
  input  logic              busy,
  input  logic              done_stky,
  input  logic              err,
  input  logic [CNT_W-1:0]  result,
  output logic              start_stb,
  output logic              abort_stb,
  output logic              clr_err_stb,
  output logic              cont,
  output logic [CNT_W-1:0]  period_reg,
  output logic [CNT_W-1:0]  width_reg,
  output logic [CNT_W-1:0]  gate_reg
);

  logic ctrl_wr;

  assign ctrl_wr     = wr_en && (addr == ADDR_W'(A_CTRL));
  // Abort takes priority: a start carried in the same byte is dropped.
  assign start_stb   = ctrl_wr && wr_data[CTRL_START] && !wr_data[CTRL_ABORT];
  assign abort_stb   = ctrl_wr && wr_data[CTRL_ABORT];
  assign clr_err_stb = ctrl_wr && wr_data[CTRL_CLR_ERR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont       <= 1'b0;
      period_reg <= CNT_W'(DEF_PERIOD);
      width_reg  <= CNT_W'(DEF_WIDTH);
      gate_reg   <= CNT_W'(DEF_GATE);
    end else if (wr_en) begin
      case (addr)
        ADDR_W'(A_CTRL):     cont                   <= wr_data[CTRL_CONT];
        ADDR_W'(A_PERIOD_L): period_reg[7:0]        <= wr_data;
        ADDR_W'(A_PERIOD_H): period_reg[CNT_W-1:8]  <= wr_data[CNT_W-9:0];
        ADDR_W'(A_WIDTH_L):  width_reg[7:0]         <= wr_data;
        ADDR_W'(A_WIDTH_H):  width_reg[CNT_W-1:8]   <= wr_data[CNT_W-9:0];
        ADDR_W'(A_GATE_L):   gate_reg[7:0]          <= wr_data;
        ADDR_W'(A_GATE_H):   gate_reg[CNT_W-1:8]    <= wr_data[CNT_W-9:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_W'(A_CTRL):     rd_data[CTRL_CONT] = cont;
      ADDR_W'(A_PERIOD_L): rd_data = byte_sel(16'(period_reg), 1'b0);
      ADDR_W'(A_PERIOD_H): rd_data = byte_sel(16'(period_reg), 1'b1);
      ADDR_W'(A_WIDTH_L):  rd_data = byte_sel(16'(width_reg), 1'b0);
      ADDR_W'(A_WIDTH_H):  rd_data = byte_sel(16'(width_reg), 1'b1);
      ADDR_W'(A_GATE_L):   rd_data = byte_sel(16'(gate_reg), 1'b0);
      ADDR_W'(A_GATE_H):   rd_data = byte_sel(16'(gate_reg), 1'b1);
      ADDR_W'(A_STATUS): begin
        rd_data[ST_BUSY] = busy;
        rd_data[ST_DONE] = done_stky;
        rd_data[ST_ERR]  = err;
      end
      ADDR_W'(A_RESULT_L): rd_data = byte_sel(16'(result), 1'b0);
      ADDR_W'(A_RESULT_H): rd_data = byte_sel(16'(result), 1'b1);
      default: ;
    endcase
  end

endmodule

// File: rtl/meas_ctrl.sv
// Measurement sequencer: runs the pulse generator and counter for a gate
// window of GATE clk cycles and captures the final count.
// Ports:
//   clk, rst_n                 div_clk domain clock / async active-low reset
//   wr_en, addr, wr_data       register write interface (I2C byte decoder)
//   rd_data                    combinational register read
//   count_in                   pulse_counter count
//   gen_run, cnt_run           generator / counter run enables
//   cnt_clear                  1-cycle counter clear
//   pulse_period, pulse_width  configuration latched at the start of each run
//   result                     last captured count
//   busy                       sequencer not idle
//   done                       1-cycle pulse when result updates
module meas_ctrl
  import meas_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DEF_PERIOD = 10,
  parameter int unsigned DEF_WIDTH  = 2,
  parameter int unsigned DEF_GATE   = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        rd_data,
  input  logic [CNT_W-1:0]  count_in,
  output logic              gen_run,
  output logic              cnt_run,
  output logic              cnt_clear,
  output logic [CNT_W-1:0]  pulse_period,
  output logic [CNT_W-1:0]  pulse_width,
  output logic [CNT_W-1:0]  result,
  output logic              busy,
  output logic              done
);

  state_t           state;
  logic [CNT_W-1:0] gate_cnt;
  logic             done_stky;
  logic             err;
  logic             start_stb;
  logic             abort_stb;
  logic             clr_err_stb;
  logic             cont;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] width_reg;
  logic [CNT_W-1:0] gate_reg;
  logic             cfg_ok;

  meas_regfile #(
    .CNT_W      (CNT_W),
    .ADDR_W     (ADDR_W),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_WIDTH  (DEF_WIDTH),
    .DEF_GATE   (DEF_GATE)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .busy        (busy),
    .done_stky   (done_stky),
    .err         (err),
    .result      (result),
    .start_stb   (start_stb),
    .abort_stb   (abort_stb),
    .clr_err_stb (clr_err_stb),
    .cont        (cont),
    .period_reg  (period_reg),
    .width_reg   (width_reg),
    .gate_reg    (gate_reg)
  );

  assign cfg_ok = (period_reg != '0) && (width_reg < period_reg) && (gate_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      gen_run      <= 1'b0;
      cnt_run      <= 1'b0;
      cnt_clear    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_stky    <= 1'b0;
      err          <= 1'b0;
      result       <= '0;
      gate_cnt     <= '0;
      pulse_period <= CNT_W'(DEF_PERIOD);
      pulse_width  <= CNT_W'(DEF_WIDTH);
    end else begin
      cnt_clear <= 1'b0;
      done      <= 1'b0;
      if (clr_err_stb) err <= 1'b0;

      if (abort_stb && (state != S_IDLE)) begin
        state   <= S_IDLE;
        gen_run <= 1'b0;
        cnt_run <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_stb) begin
              done_stky <= 1'b0;
              if (cfg_ok) begin
                state     <= S_CLEAR;
                cnt_clear <= 1'b1;
                busy      <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            pulse_period <= period_reg;
            pulse_width  <= width_reg;
            gate_cnt     <= gate_reg;
            gen_run      <= 1'b1;
            cnt_run      <= 1'b1;
            state        <= S_RUN;
          end
          S_RUN: begin
            // Exits when the last gate cycle is reached; the <2 test also
            // guards a zero load so the window never wraps.
            if (gate_cnt < CNT_W'(2)) begin
              gen_run <= 1'b0;
              state   <= S_STOP;
            end else begin
              gate_cnt <= gate_cnt - 1'b1;
            end
          end
          S_STOP: begin
            cnt_run <= 1'b0;
            state   <= S_CAPTURE;
          end
          S_CAPTURE: begin
            result    <= count_in;
            done      <= 1'b1;
            done_stky <= 1'b1;
            // Continuous mode re-checks the config, which may have been
            // rewritten during the run.
            if (cont && cfg_ok) begin
              cnt_clear <= 1'b1;
              state     <= S_CLEAR;
            end else begin
              if (cont) err <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: begin
            state   <= S_IDLE;
            gen_run <= 1'b0;
            cnt_run <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
